// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter shared by the icache and dcache miss paths.
// Data side has priority; an anti-starvation counter forces an icache grant.
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IGRANT = 2'd1;
    localparam logic [1:0] DGRANT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [1:0]       state, next_state;
    logic [CNT_W-1:0] starve_cnt, starve_next;
    logic             dreq;

    assign dreq = dREN | dWEN;

    // Outputs decode from the registered state, so an async reset forces
    // every output to its idle value without waiting for a clock edge.
    always_comb begin
        next_state  = state;
        starve_next = starve_cnt;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;
        case (state)
            IDLE: begin
                if (dreq && !(iREN && starve_cnt == CNT_MAX))
                    next_state = DGRANT;
                else if (iREN)
                    next_state = IGRANT;
            end
            IGRANT: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramstate == RAM_ACCESS) begin
                        iwait       = 1'b0;
                        iload       = ramload;
                        starve_next = '0;
                        next_state  = IDLE;
                    end else if (ramstate == RAM_ERROR) begin
                        next_state = IDLE;
                    end
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    next_state = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    if (ramstate == RAM_ACCESS) begin
                        dwait      = 1'b0;
                        next_state = IDLE;
                        if (!dWEN)
                            dload = ramload;
                        // Count only data wins that actually held off a waiting fetch.
                        if (!iREN)
                            starve_next = '0;
                        else if (starve_cnt < CNT_MAX)
                            starve_next = starve_cnt + CNT_W'(1);
                    end else if (ramstate == RAM_ERROR) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= starve_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected completions,
// a negedge monitor pops and compares them against a simple RAM model.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    mem_arbiter #(.WORD_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return (a * 32'h9E37) ^ 32'h5A5A0F0F;
    endfunction

    // RAM model: ram_lat BUSY cycles before ACCESS; err_req forces ERROR cycles.
    int  ram_lat = 0;
    int  err_req = 0;
    int  errs_done = 0;
    int  busy_cnt = 0;
    logic ram_en;
    assign ram_en  = ramREN | ramWEN;
    assign ramload = mem_val(ramaddr);

    always_comb begin
        if (!ram_en)                  ramstate = 2'd0;
        else if (errs_done < err_req) ramstate = 2'd3;
        else if (busy_cnt >= ram_lat) ramstate = 2'd2;
        else                          ramstate = 2'd1;
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (ram_en && ramstate == 2'd1) busy_cnt <= busy_cnt + 1;
        else                            busy_cnt <= 0;
        if (ram_en && ramstate == 2'd3) errs_done <= errs_done + 1;
    end

    typedef struct {
        logic        is_w;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t iq[$];
    txn_t dq[$];
    logic log_is_d[$];
    int   log_cyc[$];

    always @(negedge CLK) begin
        if (nRST) begin
            txn_t e;
            if (!iwait && !dwait) check("both_wait_low", 32'(iwait), 32'(1));
            if (!iwait) begin
                log_is_d.push_back(1'b0);
                log_cyc.push_back(cyc);
                if (iq.size() == 0) check("i_unexpected", 32'(iwait), 32'(1));
                else begin
                    e = iq.pop_front();
                    check("iload", iload, e.data);
                    check("i_ramaddr", ramaddr, e.addr);
                end
            end else begin
                check("iload_zero", iload, 32'h0);
            end
            if (!dwait) begin
                log_is_d.push_back(1'b1);
                log_cyc.push_back(cyc);
                if (dq.size() == 0) check("d_unexpected", 32'(dwait), 32'(1));
                else begin
                    e = dq.pop_front();
                    check("d_ramaddr", ramaddr, e.addr);
                    check("d_ramWEN", 32'(ramWEN), 32'(e.is_w));
                    if (e.is_w) begin
                        check("d_ramstore", ramstore, e.data);
                        check("dload_wr", dload, 32'h0);
                    end else begin
                        check("dload", dload, e.data);
                    end
                end
            end else begin
                check("dload_zero", dload, 32'h0);
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic ireq(input logic [31:0] a, input int max_cyc);
        txn_t e;
        iREN = 1'b1;
        iaddr = a;
        e.is_w = 1'b0; e.addr = a; e.data = mem_val(a);
        iq.push_back(e);
        for (int n = 0; ; n++) begin
            @(negedge CLK);
            if (!iwait) break;
            if (n >= max_cyc) begin
                check("i_timeout", 32'(iwait), 32'(0));
                break;
            end
        end
        @(posedge CLK); #1;
        iREN = 1'b0;
    endtask

    task automatic dreq(input logic w, input logic [31:0] a, input logic [31:0] d, input int max_cyc);
        txn_t e;
        dWEN = w;
        dREN = ~w;
        daddr = a;
        dstore = d;
        e.is_w = w; e.addr = a; e.data = w ? d : mem_val(a);
        dq.push_back(e);
        for (int n = 0; ; n++) begin
            @(negedge CLK);
            if (!dwait) break;
            if (n >= max_cyc) begin
                check("d_timeout", 32'(dwait), 32'(0));
                break;
            end
        end
        @(posedge CLK); #1;
        dREN = 1'b0;
        dWEN = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ramREN"}, 32'(ramREN), 32'(0));
        check({tag, "_ramWEN"}, 32'(ramWEN), 32'(0));
        check({tag, "_ramaddr"}, ramaddr, 32'h0);
        check({tag, "_ramstore"}, ramstore, 32'h0);
        check({tag, "_iwait"}, 32'(iwait), 32'(1));
        check({tag, "_dwait"}, 32'(dwait), 32'(1));
        check({tag, "_iload"}, iload, 32'h0);
        check({tag, "_dload"}, dload, 32'h0);
    endtask

    initial begin
        int first_i;
        int n_d_before;

        // 1: reset then idle
        repeat (2) @(negedge CLK);
        check_idle_outputs("rst");
        @(posedge CLK); #1;
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        check_idle_outputs("idle");
        @(posedge CLK); #1;

        // 2: single fetch with one BUSY cycle
        ram_lat = 1;
        fork
            ireq(32'h40, 10);
            begin
                @(negedge CLK);
                check("f_c0_ramREN", 32'(ramREN), 32'(0));
                @(negedge CLK);
                check("f_c1_ramREN", 32'(ramREN), 32'(1));
                check("f_c1_ramaddr", ramaddr, 32'h40);
                check("f_c1_iwait", 32'(iwait), 32'(1));
                @(negedge CLK);
                check("f_c2_iwait", 32'(iwait), 32'(0));
                @(negedge CLK);
                check("f_c3_iwait", 32'(iwait), 32'(1));
            end
        join
        @(posedge CLK); #1;

        // 3: contention, write wins, fetch follows after one idle cycle
        ram_lat = 0;
        log_is_d.delete(); log_cyc.delete();
        fork
            ireq(32'h80, 20);
            dreq(1'b1, 32'h100, 32'h12345678, 20);
        join
        check("cont_count", 32'(log_is_d.size()), 32'(2));
        if (log_is_d.size() == 2) begin
            check("cont_first_d", 32'(log_is_d[0]), 32'(1));
            check("cont_gap", 32'(log_cyc[1] - log_cyc[0]), 32'(2));
        end
        @(posedge CLK); #1;

        // 4: starvation, four data completions then the fetch
        log_is_d.delete(); log_cyc.delete();
        fork
            ireq(32'h200, 60);
            for (int k = 0; k < 6; k++) dreq(1'b0, 32'h600 + 32'(4 * k), 32'h0, 20);
        join
        first_i = -1;
        n_d_before = 0;
        foreach (log_is_d[k]) begin
            if (first_i < 0 && !log_is_d[k]) first_i = k;
            if (first_i < 0 && log_is_d[k]) n_d_before++;
        end
        check("starve_total", 32'(log_is_d.size()), 32'(7));
        check("starve_d_before_i", 32'(n_d_before), 32'(4));
        check("starve_cnt_zero", 32'(dut.starve_cnt), 32'(0));
        @(posedge CLK); #1;

        // 5: error on first grant cycle, then retried
        err_req = errs_done + 1;
        fork
            dreq(1'b0, 32'h300, 32'h0, 20);
            begin
                @(negedge CLK);
                check("err_c0_ramREN", 32'(ramREN), 32'(0));
                @(negedge CLK);
                check("err_c1_ramREN", 32'(ramREN), 32'(1));
                check("err_c1_state", 32'(ramstate), 32'(3));
                check("err_c1_dwait", 32'(dwait), 32'(1));
                @(negedge CLK);
                check("err_c2_ramREN", 32'(ramREN), 32'(0));
                check("err_c2_dwait", 32'(dwait), 32'(1));
                @(negedge CLK);
                check("err_c3_ramREN", 32'(ramREN), 32'(1));
                check("err_c3_dwait", 32'(dwait), 32'(0));
            end
        join
        @(posedge CLK); #1;

        // 6a: withdraw fetch during BUSY grant
        ram_lat = 5;
        iREN = 1'b1;
        iaddr = 32'h44;
        @(negedge CLK);
        @(negedge CLK);
        check("wd_ramREN_on", 32'(ramREN), 32'(1));
        check("wd_busy", 32'(ramstate), 32'(1));
        #1 iREN = 1'b0;
        #1 check("wd_ramREN_drop", 32'(ramREN), 32'(0));
        check("wd_iwait", 32'(iwait), 32'(1));
        @(negedge CLK);
        check("wd_idle_ramREN", 32'(ramREN), 32'(0));
        @(posedge CLK); #1;

        // 6b: async reset in the middle of a data grant
        dREN = 1'b1;
        daddr = 32'h500;
        @(negedge CLK);
        @(negedge CLK);
        check("rs_ramREN_on", 32'(ramREN), 32'(1));
        check("rs_ramaddr_on", ramaddr, 32'h500);
        #2 nRST = 1'b0;
        #1 check_idle_outputs("arst");
        dREN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        check_idle_outputs("post_rst");

        check("iq_empty", 32'(iq.size()), 32'(0));
        check("dq_empty", 32'(dq.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
